// File: rtl/acc_diag_writer_pkg.sv
// Shared types and constants for the accumulator diagonal write path.
// ACC_WR_OVF_CHECK_EN (optional) enables the address-range check helper's use in the top.
package acc_diag_writer_pkg;

  localparam int ACC_MUL_SIZE = 32;
  localparam int ACC_ADDR_W   = 7;
  localparam int ACC_RES_W    = 32;
  localparam int ACC_ROWS_W   = 8;

  typedef logic signed [ACC_RES_W-1:0] res_t;
  typedef res_t [ACC_MUL_SIZE-1:0] res_vec_t;
  typedef logic [ACC_MUL_SIZE-1:0][ACC_ADDR_W-1:0] diag_addr_array_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } acc_wr_state_t;

  // True when the tile's row span runs past the top of the accumulator.
  function automatic logic addr_range_ovf(input logic [ACC_ADDR_W-1:0] base,
                                          input logic [ACC_ROWS_W-1:0] rows);
    logic [ACC_ROWS_W:0] sum;
    sum = {{(ACC_ROWS_W + 1 - ACC_ADDR_W){1'b0}}, base} + {1'b0, rows};
    return sum > (ACC_ROWS_W + 1)'(1 << ACC_ADDR_W);
  endfunction

endpackage

// File: rtl/acc_diag_writer_if.sv
// Control handshake, skewed result input and per-column write bus of acc_diag_writer.
interface acc_diag_writer_if;
  import acc_diag_writer_pkg::*;

  logic                         start_i;
  logic [ACC_ADDR_W-1:0]        base_addr_i;
  logic [ACC_ROWS_W-1:0]        num_rows_i;
  logic                         accumulate_i;
  logic                         row_valid_i;
  res_vec_t                     res_i;

  logic [ACC_MUL_SIZE-1:0]      wr_en_o;
  diag_addr_array_t             wr_addr_o;
  res_vec_t                     wr_data_o;
  logic                         wr_acc_o;
  logic                         busy_o;
  logic                         done_o;
  logic                         ovf_o;

  modport slave (
    input  start_i, base_addr_i, num_rows_i, accumulate_i, row_valid_i, res_i,
    output wr_en_o, wr_addr_o, wr_data_o, wr_acc_o, busy_o, done_o, ovf_o
  );

  modport master (
    output start_i, base_addr_i, num_rows_i, accumulate_i, row_valid_i, res_i,
    input  wr_en_o, wr_addr_o, wr_data_o, wr_acc_o, busy_o, done_o, ovf_o
  );

endinterface

// File: rtl/acc_diag_writer_lane.sv
// One write lane: valid skew stage, per-column row counter and registered write outputs.
module acc_wr_lane
  import acc_diag_writer_pkg::*;
#(
  parameter int ADDR_W = ACC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] base_i,
  input  res_t              res_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output res_t              wr_data_o
);

  logic              en_q, en_d;
  logic [ADDR_W-1:0] rowcnt_q, rowcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  res_t              data_q, data_d;

  // The strobe register doubles as this column's valid stage for the next lane.
  always_comb begin
    en_d     = valid_i;
    rowcnt_d = rowcnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (valid_i) begin
      addr_d   = base_i + rowcnt_q;
      data_d   = res_i;
      rowcnt_d = rowcnt_q + ADDR_W'(1);
    end
    if (clr_i) begin
      rowcnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      rowcnt_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      en_q     <= en_d;
      rowcnt_q <= rowcnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign wr_en_o   = en_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;

endmodule

// File: rtl/acc_diag_writer.sv
// Turns skewed systolic-array result rows into per-column accumulator writes.
// Optional macro ACC_WR_OVF_CHECK_EN: sticky ovf_o when a tile runs past the top row.
module acc_diag_writer
  import acc_diag_writer_pkg::*;
#(
  parameter int MUL_SIZE = ACC_MUL_SIZE,
  parameter int ADDR_W   = ACC_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  acc_diag_writer_if.slave   bus
);

  acc_wr_state_t         state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic                  acc_q, acc_d;
  logic [ACC_ROWS_W-1:0] num_rows_q, num_rows_d;
  logic [ACC_ROWS_W-1:0] accepted_q, accepted_d;
  logic                  done_q, done_d;

  logic                  start_acc;
  logic                  tok_in;
  logic                  busy;
  logic [MUL_SIZE-1:0]   stage_en;
  logic [MUL_SIZE-1:0]   lane_in;
  diag_addr_array_t      wr_addr;
  res_vec_t              wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DRAIN exits while the last token is entering the final column, because done is registered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start_i) state_d = (bus.num_rows_i == '0) ? DONE : RUN;
      RUN:   if (bus.row_valid_i && (accepted_q + 8'd1 == num_rows_q)) state_d = DRAIN;
      DRAIN: if (stage_en[MUL_SIZE-3:0] == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_acc = (state_q == IDLE) && bus.start_i;
    tok_in    = (state_q == RUN) && bus.row_valid_i;
    busy      = (state_q != IDLE);
    done_d    = (state_q == DONE);
  end

  always_comb begin
    base_d     = base_q;
    acc_d      = acc_q;
    num_rows_d = num_rows_q;
    accepted_d = accepted_q;
    if (start_acc) begin
      base_d     = bus.base_addr_i;
      acc_d      = bus.accumulate_i;
      num_rows_d = bus.num_rows_i;
      accepted_d = '0;
    end else if (tok_in) begin
      accepted_d = accepted_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      acc_q      <= 1'b0;
      num_rows_q <= '0;
      accepted_q <= '0;
      done_q     <= 1'b0;
    end else begin
      base_q     <= base_d;
      acc_q      <= acc_d;
      num_rows_q <= num_rows_d;
      accepted_q <= accepted_d;
      done_q     <= done_d;
    end
  end

  assign lane_in = {stage_en[MUL_SIZE-2:0], tok_in};

  generate
    for (genvar gi = 0; gi < MUL_SIZE; gi++) begin : g_lane
      acc_wr_lane #(
        .ADDR_W (ADDR_W)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (start_acc),
        .valid_i   (lane_in[gi]),
        .base_i    (base_q),
        .res_i     (bus.res_i[gi]),
        .wr_en_o   (stage_en[gi]),
        .wr_addr_o (wr_addr[gi]),
        .wr_data_o (wr_data[gi])
      );
    end
  endgenerate

`ifdef ACC_WR_OVF_CHECK_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (start_acc) begin
      ovf_d = addr_range_ovf(bus.base_addr_i, bus.num_rows_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf_o = ovf_q;
`else
  assign bus.ovf_o = 1'b0;
`endif

  assign bus.wr_en_o   = stage_en;
  assign bus.wr_addr_o = wr_addr;
  assign bus.wr_data_o = wr_data;
  assign bus.wr_acc_o  = acc_q;
  assign bus.busy_o    = busy;
  assign bus.done_o    = done_q;

endmodule
